// File: rtl/ex_pkg.sv
// Shared encodings for the RVX execute stage: control-word bit positions,
// ALU op codes and branch comparison codes.
package ex_pkg;

    localparam int EXOP_W        = 12;
    localparam int BRANCH_OP_MSB = 11;
    localparam int BRANCH_OP_LSB = 9;
    localparam int ALU_OP_MSB    = 8;
    localparam int ALU_OP_LSB    = 5;
    localparam int SRC_A         = 4;
    localparam int SRC_B         = 3;
    localparam int ALU_EN        = 2;
    localparam int BRANCH_EN     = 1;
    localparam int WORK_EN       = 0;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b1000;
    localparam logic [3:0] ALU_SLL     = 4'b0001;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_SRA     = 4'b1101;
    localparam logic [3:0] ALU_SLT     = 4'b0010;
    localparam logic [3:0] ALU_SLTU    = 4'b0011;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_OR      = 4'b0110;
    localparam logic [3:0] ALU_AND     = 4'b0111;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage; zero latency, no handshake.
// Unlisted op codes return 0 and raise illegal.
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: ALU/branch compare into a one-entry EX/MEM slot, 1-cycle latency.
// inReady drops while the slot is held (outValid && !outReady) or on flush; consume+refill is bubble-free.
module execute_unit
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [EXOP_W-1:0] exOp,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1Data,
    input  logic [XLEN-1:0]   rs2Data,
    input  logic [XLEN-1:0]   imm,
    input  logic [4:0]        rdAddr,
    output logic              outValid,
    input  logic              outReady,
    output logic [XLEN-1:0]   outResult,
    output logic [XLEN-1:0]   outRs2Data,
    output logic [4:0]        outRdAddr,
    output logic              redirectValid,
    output logic [XLEN-1:0]   redirectPc,
    output logic              illegalOp
);

    logic [2:0]      branch_op;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    logic            taken;
    logic            work;
    logic            take_branch;

    assign branch_op = exOp[BRANCH_OP_MSB:BRANCH_OP_LSB];
    assign alu_op    = exOp[ALU_OP_MSB:ALU_OP_LSB];
    assign op_a      = exOp[SRC_A] ? pc  : rs1Data;
    assign op_b      = exOp[SRC_B] ? imm : rs2Data;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .alu_op  (alu_op),
        .a       (op_a),
        .b       (op_b),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    always_comb begin
        taken = 1'b0;
        case (branch_op)
            BR_BEQ:  taken = (rs1Data == rs2Data);
            BR_BNE:  taken = (rs1Data != rs2Data);
            BR_BLT:  taken = ($signed(rs1Data) <  $signed(rs2Data));
            BR_BGE:  taken = ($signed(rs1Data) >= $signed(rs2Data));
            BR_BLTU: taken = (rs1Data <  rs2Data);
            BR_BGEU: taken = (rs1Data >= rs2Data);
            default: taken = 1'b0;
        endcase
    end

    assign inReady     = !flush && (!outValid || outReady);
    // workEn=0 instructions are accepted but leave no trace at all
    assign work        = inValid && inReady && exOp[WORK_EN];
    assign take_branch = work && exOp[BRANCH_EN] && taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid      <= 1'b0;
            outResult     <= '0;
            outRs2Data    <= '0;
            outRdAddr     <= '0;
            redirectValid <= 1'b0;
            redirectPc    <= '0;
            illegalOp     <= 1'b0;
        end else if (flush) begin
            outValid      <= 1'b0;
            redirectValid <= 1'b0;
            illegalOp     <= 1'b0;
        end else begin
            redirectValid <= take_branch;
            illegalOp     <= work && exOp[ALU_EN] && alu_illegal;
            if (take_branch) begin
                redirectPc <= pc + imm;
            end
            if (work) begin
                outValid   <= 1'b1;
                outResult  <= exOp[ALU_EN] ? alu_result : '0;
                outRs2Data <= rs2Data;
                outRdAddr  <= rdAddr;
            end else if (outReady) begin
                outValid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit with a queue scoreboard of expected slot contents.
module tb_execute_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [11:0] exOp;
    logic [31:0] pc;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] imm;
    logic [4:0]  rdAddr;
    logic        outValid;
    logic        outReady;
    logic [31:0] outResult;
    logic [31:0] outRs2Data;
    logic [4:0]  outRdAddr;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        illegalOp;

    execute_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .inValid       (inValid),
        .inReady       (inReady),
        .exOp          (exOp),
        .pc            (pc),
        .rs1Data       (rs1Data),
        .rs2Data       (rs2Data),
        .imm           (imm),
        .rdAddr        (rdAddr),
        .outValid      (outValid),
        .outReady      (outReady),
        .outResult     (outResult),
        .outRs2Data    (outRs2Data),
        .outRdAddr     (outRdAddr),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc),
        .illegalOp     (illegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rs2;
        logic [4:0]  rd;
    } slot_t;

    slot_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] p_res;
    logic        p_tk;
    logic [31:0] p_rpc;
    logic        p_ill;
    logic        exp_redir = 1'b0;
    logic [31:0] exp_rpc   = '0;
    logic        exp_ill   = 1'b0;

    function automatic logic [11:0] mk(input logic [2:0] bop, input logic [3:0] aop,
                                       input logic sa, input logic sb, input logic ae,
                                       input logic be, input logic we);
        return {bop, aop, sa, sb, ae, be, we};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_instr(input logic [11:0] op, input logic [31:0] pc_i,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] im, input logic [4:0] rd,
                             input logic [31:0] e_res, input logic e_tk,
                             input logic [31:0] e_rpc, input logic e_ill);
        exOp    = op;
        pc      = pc_i;
        rs1Data = r1;
        rs2Data = r2;
        imm     = im;
        rdAddr  = rd;
        p_res   = e_res;
        p_tk    = e_tk;
        p_rpc   = e_rpc;
        p_ill   = e_ill;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".outValid"}, {31'b0, outValid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk({tag, ".outResult"}, outResult, exp_q[0].res);
            chk({tag, ".outRs2Data"}, outRs2Data, exp_q[0].rs2);
            chk({tag, ".outRdAddr"}, {27'b0, outRdAddr}, {27'b0, exp_q[0].rd});
        end
        chk({tag, ".redirectValid"}, {31'b0, redirectValid}, {31'b0, exp_redir});
        if (exp_redir) chk({tag, ".redirectPc"}, redirectPc, exp_rpc);
        chk({tag, ".illegalOp"}, {31'b0, illegalOp}, {31'b0, exp_ill});
    endtask

    // One clock: drive handshake inputs, check inReady, advance the model, check outputs.
    task automatic cyc(input string tag, input logic v, input logic f, input logic ordy);
        logic  rdy_exp;
        logic  acc;
        slot_t s;
        inValid  = v;
        flush    = f;
        outReady = ordy;
        #1;
        rdy_exp = !f && ((exp_q.size() == 0) || ordy);
        chk({tag, ".inReady"}, {31'b0, inReady}, {31'b0, rdy_exp});
        acc = v && rdy_exp;
        @(posedge clk);
        #1;
        if (f) begin
            exp_q.delete();
            exp_redir = 1'b0;
            exp_ill   = 1'b0;
        end else begin
            if (exp_q.size() != 0 && ordy) s = exp_q.pop_front();
            if (acc && exOp[0]) begin
                s.res = p_res;
                s.rs2 = rs2Data;
                s.rd  = rdAddr;
                exp_q.push_back(s);
            end
            exp_redir = acc && exOp[0] && p_tk;
            exp_ill   = acc && exOp[0] && p_ill;
            exp_rpc   = p_rpc;
        end
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        set_instr(12'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.outValid", {31'b0, outValid}, 32'h0);
        chk("rst.redirectValid", {31'b0, redirectValid}, 32'h0);
        chk("rst.illegalOp", {31'b0, illegalOp}, 32'h0);
        chk("rst.outResult", outResult, 32'h0);
        chk("rst.outRs2Data", outRs2Data, 32'h0);
        chk("rst.outRdAddr", {27'b0, outRdAddr}, 32'h0);
        chk("rst.redirectPc", redirectPc, 32'h0);
        rst = 1'b0;

        // ALU ops, back to back with downstream always ready
        set_instr(mk(3'b000, 4'b0000, 0, 1, 1, 0, 1), 32'h0, 32'd5, 32'hAA, 32'hFFFF_FFFF, 5'd3,
                  32'd4, 0, 32'h0, 0);
        cyc("add", 1, 0, 1);
        set_instr(mk(3'b000, 4'b1101, 0, 1, 1, 0, 1), 32'h0, 32'h8000_0000, 32'h11, 32'd4, 5'd4,
                  32'hF800_0000, 0, 32'h0, 0);
        cyc("sra", 1, 0, 1);
        set_instr(mk(3'b000, 4'b0101, 0, 1, 1, 0, 1), 32'h0, 32'h8000_0000, 32'h12, 32'd4, 5'd5,
                  32'h0800_0000, 0, 32'h0, 0);
        cyc("srl", 1, 0, 1);
        set_instr(mk(3'b000, 4'b0010, 0, 0, 1, 0, 1), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd6,
                  32'd1, 0, 32'h0, 0);
        cyc("slt", 1, 0, 1);
        set_instr(mk(3'b000, 4'b0011, 0, 0, 1, 0, 1), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd7,
                  32'd0, 0, 32'h0, 0);
        cyc("sltu", 1, 0, 1);
        set_instr(mk(3'b000, 4'b1000, 0, 0, 1, 0, 1), 32'h0, 32'd3, 32'd5, 32'h0, 5'd8,
                  32'hFFFF_FFFE, 0, 32'h0, 0);
        cyc("sub", 1, 0, 1);
        set_instr(mk(3'b000, 4'b0100, 0, 0, 1, 0, 1), 32'h0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'd9,
                  32'h0000_0FF0, 0, 32'h0, 0);
        cyc("xor", 1, 0, 1);
        set_instr(mk(3'b000, 4'b0111, 0, 0, 1, 0, 1), 32'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 5'd10,
                  32'h0F00_0F00, 0, 32'h0, 0);
        cyc("and", 1, 0, 1);
        set_instr(mk(3'b000, 4'b0110, 0, 0, 1, 0, 1), 32'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 5'd11,
                  32'hFFF0_FFF0, 0, 32'h0, 0);
        cyc("or", 1, 0, 1);
        set_instr(mk(3'b000, 4'b0001, 0, 1, 1, 0, 1), 32'h0, 32'd1, 32'h0, 32'h23, 5'd12,
                  32'd8, 0, 32'h0, 0);
        cyc("sll_mask", 1, 0, 1);
        set_instr(mk(3'b000, 4'b0000, 1, 1, 1, 0, 1), 32'h100, 32'h55, 32'h0, 32'd8, 5'd13,
                  32'h108, 0, 32'h0, 0);
        cyc("pc_plus_imm", 1, 0, 1);

        // Branches
        set_instr(mk(3'b100, 4'b0000, 0, 0, 0, 1, 1), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd1,
                  32'd0, 1, 32'h120, 0);
        cyc("blt", 1, 0, 1);
        set_instr(mk(3'b110, 4'b0000, 0, 0, 0, 1, 1), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd1,
                  32'd0, 0, 32'h0, 0);
        cyc("bltu", 1, 0, 1);
        set_instr(mk(3'b101, 4'b0000, 0, 0, 0, 1, 1), 32'h300, 32'd1, 32'hFFFF_FFFF, 32'h10, 5'd2,
                  32'd0, 1, 32'h310, 0);
        cyc("bge", 1, 0, 1);
        set_instr(mk(3'b111, 4'b0000, 0, 0, 0, 1, 1), 32'h300, 32'd1, 32'hFFFF_FFFF, 32'h10, 5'd2,
                  32'd0, 0, 32'h0, 0);
        cyc("bgeu", 1, 0, 1);
        set_instr(mk(3'b001, 4'b0000, 0, 0, 0, 1, 1), 32'h300, 32'd7, 32'd7, 32'h10, 5'd2,
                  32'd0, 0, 32'h0, 0);
        cyc("bne_eq", 1, 0, 1);
        set_instr(mk(3'b010, 4'b0000, 0, 0, 0, 1, 1), 32'h300, 32'd7, 32'd7, 32'h10, 5'd2,
                  32'd0, 0, 32'h0, 0);
        cyc("br_010", 1, 0, 1);
        cyc("idle", 0, 0, 1);

        // Backpressure on a taken branch: redirect must not repeat while stalled
        set_instr(mk(3'b000, 4'b0000, 0, 0, 0, 1, 1), 32'h200, 32'd7, 32'd7, 32'hFFFF_FFF0, 5'd0,
                  32'd0, 1, 32'h1F0, 0);
        cyc("beq_wrap", 1, 0, 1);
        set_instr(mk(3'b000, 4'b1000, 0, 0, 1, 0, 1), 32'h0, 32'd3, 32'd5, 32'h0, 5'd9,
                  32'hFFFF_FFFE, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) cyc("stall", 1, 0, 0);
        cyc("refill", 1, 0, 1);

        // Flush with a full slot and a taken branch on the input
        set_instr(mk(3'b100, 4'b0000, 0, 0, 0, 1, 1), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd1,
                  32'd0, 1, 32'h120, 0);
        cyc("flush", 1, 1, 0);
        cyc("post_flush", 0, 0, 1);

        // Illegal ops and dropped (workEn=0) instructions
        set_instr(mk(3'b000, 4'b1111, 0, 0, 1, 0, 1), 32'h0, 32'd9, 32'd4, 32'h0, 5'd14,
                  32'd0, 0, 32'h0, 1);
        cyc("ill_1111", 1, 0, 1);
        set_instr(mk(3'b000, 4'b1001, 0, 0, 1, 0, 1), 32'h0, 32'd9, 32'd4, 32'h0, 5'd15,
                  32'd0, 0, 32'h0, 1);
        cyc("ill_1001", 1, 0, 1);
        cyc("ill_gone", 0, 0, 1);
        set_instr(mk(3'b000, 4'b1111, 0, 0, 1, 1, 0), 32'h40, 32'd7, 32'd7, 32'h8, 5'd16,
                  32'd0, 1, 32'h48, 1);
        cyc("drop", 1, 0, 1);
        cyc("drop_idle", 0, 0, 1);

        // Reset while the slot is stalled
        set_instr(mk(3'b000, 4'b0000, 0, 1, 1, 0, 1), 32'h0, 32'd1, 32'd2, 32'd1, 5'd17,
                  32'd2, 0, 32'h0, 0);
        cyc("pre_rst", 1, 0, 0);
        cyc("pre_rst_stall", 1, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_redir = 1'b0;
        exp_ill   = 1'b0;
        check_outputs("mid_rst");
        chk("mid_rst.outResult", outResult, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
